// File: rtl/trackball_emulator.sv
// trackball_emulator: turns MiSTer mouse packets and joystick directions into player-1 trackball
// quadrature pairs. Define TRACKBALL_JOY_ACCEL_EN for a 4x joystick rate after a long hold.
module trackball_emulator #(
  parameter int CNT_W     = 10,
  parameter int STEP_DIV  = 64,
  parameter int JOY_DIV   = 256,
  parameter int MOUSE_SHL = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       enable,
  input  logic       joy_l,
  input  logic       joy_r,
  input  logic       joy_u,
  input  logic       joy_d,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic       mouse_strobe,
  output logic       x_qa,
  output logic       x_qb,
  output logic       y_qa,
  output logic       y_qb
);

  localparam int SDW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int JDW = (JOY_DIV > 1) ? $clog2(JOY_DIV) : 1;
  // Wide enough that a shifted packet plus a full accumulator cannot overflow before the clamp.
  localparam int AW  = CNT_W + 12;
  localparam logic signed [AW-1:0] ACC_MAX = AW'((2 ** (CNT_W - 1)) - 1);
  localparam logic signed [AW-1:0] ACC_MIN = -ACC_MAX;

  logic [SDW-1:0]          step_cnt_r;
  logic [JDW-1:0]          joy_cnt_r;
  logic                    strobe_prev_r;
  logic                    armed_r;
  logic signed [CNT_W-1:0] acc_x_r;
  logic signed [CNT_W-1:0] acc_y_r;
  logic [1:0]              phase_x_r;
  logic [1:0]              phase_y_r;

  logic                    tick_s;
  logic                    step_wrap_s;
  logic                    joy_wrap_s;
  logic                    pkt_s;
  logic [1:0]              dir_x_s;
  logic [1:0]              dir_y_s;
  logic                    fire_x_s;
  logic                    fire_y_s;
  logic signed [AW-1:0]    pkt_x_s;
  logic signed [AW-1:0]    pkt_y_s;
  logic signed [AW-1:0]    sum_x_s;
  logic signed [AW-1:0]    sum_y_s;

  function automatic logic signed [CNT_W-1:0] sat_acc(input logic signed [AW-1:0] v);
    if (v > ACC_MAX) begin
      return ACC_MAX[CNT_W-1:0];
    end else if (v < ACC_MIN) begin
      return ACC_MIN[CNT_W-1:0];
    end else begin
      return v[CNT_W-1:0];
    end
  endfunction

  // dir is {positive, negative}; both or neither cancel to zero.
  function automatic logic signed [AW-1:0] inject_val(input logic fire, input logic [1:0] dir);
    if (fire && dir == 2'b10) begin
      return {{(AW-1){1'b0}}, 1'b1};
    end else if (fire && dir == 2'b01) begin
      return {AW{1'b1}};
    end else begin
      return {AW{1'b0}};
    end
  endfunction

  function automatic logic signed [AW-1:0] step_val(input logic wrap, input logic signed [CNT_W-1:0] acc);
    if (!wrap || acc == {CNT_W{1'b0}}) begin
      return {AW{1'b0}};
    end else if (acc[CNT_W-1]) begin
      return {AW{1'b1}};
    end else begin
      return {{(AW-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic fwd);
    case ({fwd, ph})
      3'b1_00: return 2'b01;
      3'b1_01: return 2'b11;
      3'b1_11: return 2'b10;
      3'b1_10: return 2'b00;
      3'b0_00: return 2'b10;
      3'b0_10: return 2'b11;
      3'b0_11: return 2'b01;
      3'b0_01: return 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  assign tick_s      = ce & enable;
  assign step_wrap_s = tick_s & (step_cnt_r == SDW'(STEP_DIV - 1));
  assign joy_wrap_s  = tick_s & (joy_cnt_r == JDW'(JOY_DIV - 1));
  assign pkt_s       = armed_r & (mouse_strobe != strobe_prev_r);
  assign dir_x_s     = {joy_r & ~joy_l, joy_l & ~joy_r};
  assign dir_y_s     = {joy_d & ~joy_u, joy_u & ~joy_d};

  assign pkt_x_s = pkt_s ? (AW'($signed(mouse_dx)) <<< MOUSE_SHL) : {AW{1'b0}};
  assign pkt_y_s = pkt_s ? -(AW'($signed(mouse_dy)) <<< MOUSE_SHL) : {AW{1'b0}};
  assign sum_x_s = AW'(acc_x_r) + pkt_x_s + inject_val(fire_x_s, dir_x_s) - step_val(step_wrap_s, acc_x_r);
  assign sum_y_s = AW'(acc_y_r) + pkt_y_s + inject_val(fire_y_s, dir_y_s) - step_val(step_wrap_s, acc_y_r);

`ifdef TRACKBALL_JOY_ACCEL_EN
  logic [5:0] hold_x_r;
  logic [5:0] hold_y_r;
  logic [1:0] last_x_r;
  logic [1:0] last_y_r;
  logic       quarter_wrap_s;

  function automatic logic [5:0] hold_next(input logic [5:0] hold, input logic [1:0] last,
                                           input logic [1:0] dir, input logic fire);
    if (dir == 2'b00 || dir != last) begin
      return 6'd0;
    end else if (fire && hold != 6'd63) begin
      return hold + 6'd1;
    end else begin
      return hold;
    end
  endfunction

  assign quarter_wrap_s = tick_s & ((joy_cnt_r % JDW'(JOY_DIV / 4)) == JDW'(JOY_DIV / 4 - 1));
  assign fire_x_s = (dir_x_s != 2'b00) & (joy_wrap_s | ((hold_x_r == 6'd63) & quarter_wrap_s));
  assign fire_y_s = (dir_y_s != 2'b00) & (joy_wrap_s | ((hold_y_r == 6'd63) & quarter_wrap_s));

  // Per-axis hold counters; a released or reversed stick starts the ramp over.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_x_r <= 6'd0;
      hold_y_r <= 6'd0;
      last_x_r <= 2'b00;
      last_y_r <= 2'b00;
    end else begin
      hold_x_r <= hold_next(hold_x_r, last_x_r, dir_x_s, fire_x_s);
      hold_y_r <= hold_next(hold_y_r, last_y_r, dir_y_s, fire_y_s);
      last_x_r <= dir_x_s;
      last_y_r <= dir_y_s;
    end
  end
`else
  assign fire_x_s = (dir_x_s != 2'b00) & joy_wrap_s;
  assign fire_y_s = (dir_y_s != 2'b00) & joy_wrap_s;
`endif

  // Strobe edge detector (armed one cycle after reset) and the shared step/joystick dividers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_prev_r <= 1'b0;
      armed_r       <= 1'b0;
      step_cnt_r    <= {SDW{1'b0}};
      joy_cnt_r     <= {JDW{1'b0}};
    end else begin
      strobe_prev_r <= mouse_strobe;
      armed_r       <= 1'b1;
      if (tick_s) begin
        step_cnt_r <= step_wrap_s ? {SDW{1'b0}} : step_cnt_r + 1'b1;
        joy_cnt_r  <= joy_wrap_s ? {JDW{1'b0}} : joy_cnt_r + 1'b1;
      end
    end
  end

  // Pending-step accumulators and Gray phase registers that drive the outputs directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_x_r   <= {CNT_W{1'b0}};
      acc_y_r   <= {CNT_W{1'b0}};
      phase_x_r <= 2'b00;
      phase_y_r <= 2'b00;
    end else begin
      acc_x_r <= sat_acc(sum_x_s);
      acc_y_r <= sat_acc(sum_y_s);
      if (step_wrap_s && acc_x_r != {CNT_W{1'b0}}) begin
        phase_x_r <= phase_step(phase_x_r, ~acc_x_r[CNT_W-1]);
      end
      if (step_wrap_s && acc_y_r != {CNT_W{1'b0}}) begin
        phase_y_r <= phase_step(phase_y_r, ~acc_y_r[CNT_W-1]);
      end
    end
  end

  assign x_qa = phase_x_r[1];
  assign x_qb = phase_x_r[0];
  assign y_qa = phase_y_r[1];
  assign y_qb = phase_y_r[0];

endmodule

// File: tb/tb_trackball_emulator.sv
// Directed bench for trackball_emulator: counts Gray-code edges per axis and compares them
// with hand-computed step counts (STEP_DIV=8, JOY_DIV=32, MOUSE_SHL=1, CNT_W=10).
module tb_trackball_emulator;
  localparam int STEP_DIV = 8;
  localparam int JOY_DIV  = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic       enable = 1'b1;
  logic       joy_l = 1'b0, joy_r = 1'b0, joy_u = 1'b0, joy_d = 1'b0;
  logic [8:0] mouse_dx = 9'd0;
  logic [8:0] mouse_dy = 9'd0;
  logic       mouse_strobe = 1'b1;
  logic       x_qa, x_qb, y_qa, y_qb;

  int checks = 0;
  int errors = 0;
  int fx = 0, bx = 0, fy = 0, by = 0, bad = 0;
  logic [1:0] prev_x = 2'b00, prev_y = 2'b00;
  logic [1:0] seq_x [$];
  logic [1:0] exp_seq [6];

  always #50 clk = ~clk;

  trackball_emulator #(.CNT_W(10), .STEP_DIV(STEP_DIV), .JOY_DIV(JOY_DIV), .MOUSE_SHL(1)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
    .joy_l(joy_l), .joy_r(joy_r), .joy_u(joy_u), .joy_d(joy_d),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_strobe(mouse_strobe),
    .x_qa(x_qa), .x_qb(x_qb), .y_qa(y_qa), .y_qb(y_qb)
  );

  function automatic int gidx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Edge monitor: classify every output change as forward, backward or an illegal double flip.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_x = 2'b00;
      prev_y = 2'b00;
    end else begin
      if ({x_qa, x_qb} != prev_x) begin
        case ((gidx({x_qa, x_qb}) - gidx(prev_x)) & 3)
          1:       fx++;
          3:       bx++;
          default: bad++;
        endcase
        seq_x.push_back({x_qa, x_qb});
        prev_x = {x_qa, x_qb};
      end
      if ({y_qa, y_qb} != prev_y) begin
        case ((gidx({y_qa, y_qb}) - gidx(prev_y)) & 3)
          1:       fy++;
          3:       by++;
          default: bad++;
        endcase
        prev_y = {y_qa, y_qb};
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic ce_ticks(input int n);
    repeat (n) begin
      @(posedge clk); #1 ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0;
    end
  endtask

  task automatic send_packet(input logic [8:0] dx, input logic [8:0] dy);
    @(posedge clk); #1;
    mouse_dx = dx;
    mouse_dy = dy;
    mouse_strobe = ~mouse_strobe;
    @(posedge clk); #1;
  endtask

  task automatic clear_counts();
    fx = 0; bx = 0; fy = 0; by = 0;
    seq_x.delete();
  endtask

  initial begin
    exp_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};

    // Reset with the strobe already high: must never count as a packet.
    repeat (3) @(posedge clk);
    #1 check_eq("reset_outputs", {x_qa, x_qb, y_qa, y_qb}, 4'b0000);
    reset_n = 1'b1;
    ce_ticks(10 * STEP_DIV);
    check_eq("strobe_high_edges", fx + bx + fy + by, 0);
    check_eq("strobe_high_outputs", {x_qa, x_qb, y_qa, y_qb}, 4'b0000);

    // dx=+3 shifted by 1 -> six forward x steps, y static.
    clear_counts();
    send_packet(9'd3, 9'd0);
    ce_ticks(10 * STEP_DIV);
    check_eq("dx3_fwd", fx, 6);
    check_eq("dx3_bwd", bx, 0);
    check_eq("dx3_y_static", fy + by, 0);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("dx3_seq%0d", i), (i < seq_x.size()) ? 32'(seq_x[i]) : 32'hFFFF, 32'(exp_seq[i]));

    // dy=+1 (up) -> -2 on y: two backward steps 00->10->11.
    clear_counts();
    send_packet(9'd0, 9'd1);
    ce_ticks(6 * STEP_DIV);
    check_eq("dy1_bwd", by, 2);
    check_eq("dy1_fwd", fy, 0);
    check_eq("dy1_y_phase", {y_qa, y_qb}, 2'b11);
    check_eq("dy1_x_static", fx + bx, 0);

    // Two +255 packets -> 1020 clamps at +511, exactly 511 forward steps.
    clear_counts();
    send_packet(9'd255, 9'd0);
    send_packet(9'd255, 9'd0);
    ce_ticks(525 * STEP_DIV);
    check_eq("sat_pos_fwd", fx, 511);
    check_eq("sat_pos_bwd", bx, 0);

    // One -256 packet -> -512 clamps at -511.
    clear_counts();
    send_packet(9'h100, 9'd0);
    ce_ticks(525 * STEP_DIV);
    check_eq("sat_neg_bwd", bx, 511);
    check_eq("sat_neg_fwd", fx, 0);

    // joy_r held for 4 joystick periods -> 4 forward x steps.
    clear_counts();
    joy_r = 1'b1;
    ce_ticks(4 * JOY_DIV);
    joy_r = 1'b0;
    ce_ticks(2 * STEP_DIV);
    check_eq("joy_r_fwd", fx, 4);
    check_eq("joy_r_bwd", bx, 0);

    // Both left and right cancel.
    clear_counts();
    joy_l = 1'b1; joy_r = 1'b1;
    ce_ticks(4 * JOY_DIV);
    joy_l = 1'b0; joy_r = 1'b0;
    ce_ticks(2 * STEP_DIV);
    check_eq("joy_lr_steps", fx + bx, 0);

    // joy_u for 2 periods -> 2 backward y steps.
    clear_counts();
    joy_u = 1'b1;
    ce_ticks(2 * JOY_DIV);
    joy_u = 1'b0;
    ce_ticks(2 * STEP_DIV);
    check_eq("joy_u_bwd", by, 2);
    check_eq("joy_u_fwd", fy, 0);

    // enable=0: packet accumulates, joystick suppressed, no edges; release drains 6 steps.
    clear_counts();
    enable = 1'b0;
    joy_r = 1'b1;
    send_packet(9'd3, 9'd0);
    ce_ticks(200);
    check_eq("disabled_edges", fx + bx + fy + by, 0);
    joy_r = 1'b0;
    enable = 1'b1;
    ce_ticks(10 * STEP_DIV);
    check_eq("enabled_fwd", fx, 6);
    check_eq("enabled_bwd", bx, 0);

    // Reset mid-motion: phases drop to 00 at once and the pending steps are discarded.
    send_packet(9'd100, 9'd0);
    ce_ticks(3 * STEP_DIV);
    @(posedge clk); #1 reset_n = 1'b0;
    #1 check_eq("midreset_outputs", {x_qa, x_qb, y_qa, y_qb}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_counts();
    ce_ticks(10 * STEP_DIV);
    check_eq("post_reset_edges", fx + bx + fy + by, 0);

`ifdef TRACKBALL_JOY_ACCEL_EN
    // After 63+ injects the rate rises to one step per JOY_DIV/4 ticks.
    joy_r = 1'b1;
    ce_ticks(70 * JOY_DIV);
    clear_counts();
    ce_ticks(4 * JOY_DIV);
    check_eq("accel_fwd", fx, 16);
    joy_r = 1'b0;
    ce_ticks(4 * STEP_DIV);
`endif

    check_eq("illegal_edges", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
